slave_rd_sched: RTL



---
 rtl/upum_pkg.sv | 26 ++
 rtl/slave_rd_sched_rr_arbiter.sv | 32 +++
 rtl/slave_rd_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/upum_pkg.sv
// Shared types and constants for the slave read scheduler: FSM encoding, frame constants
// and the round-robin pointer helper.
package upum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam int         FRAME_OVH   = 4;

  // Search start for the next arbitration round: one past the last winner, wrapping at n.
  function automatic logic [7:0] next_ptr(input logic [7:0] last, input int n);
    return 8'((int'(last) + 1) % n);
  endfunction

  function automatic int frame_bytes(input logic [7:0] len);
    return int'(len) + FRAME_OVH;
  endfunction

endpackage

// File: rtl/slave_rd_sched_rr_arbiter.sv
// Round-robin pick of the first set request at or after ptr, wrapping; purely combinational,
// zero latency, no backpressure of its own.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [7:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [7:0]   idx,
  output logic         any
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = 8'h00;
    any = 1'b0;
    jj  = '0;
    for (int i = 0; i < N; i++) begin
      jj = IW'((int'(ptr) + i) % N);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = 8'(jj);
      end
    end
  end

endmodule

// File: rtl/slave_rd_sched.sv
// Round-robin framer: SOF/addr/len/data/chk bytes per granted channel, first byte one cycle
// after request; tx_ready low holds the tx register, one idle cycle between bytes.
module slave_rd_sched
  import upum_pkg::*;
#(
  parameter int         N         = 2,
  parameter logic [7:0] SOF       = SOF_DEFAULT,
  parameter logic [7:0] ADDR_BASE = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   have_msg_bus,
  input  logic [N*8-1:0] len_bus,
  input  logic [N*8-1:0] slave_data_bus,
  output logic [N-1:0]   rdreq_bus,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy,
  output logic [7:0]     grant_idx
);

  state_t       state;
  logic [7:0]   last_grant;
  logic [7:0]   len_q;
  logic [7:0]   cnt;
  logic [7:0]   chk;
  logic [N-1:0] gnt_q;

  logic [N-1:0] arb_gnt;
  logic [7:0]   arb_idx;
  logic         arb_any;
  logic [7:0]   arb_ptr;
  logic [7:0]   sel_len;
  logic [7:0]   sel_data;
  logic [7:0]   addr_byte;
  logic         accept;

  assign arb_ptr   = next_ptr(last_grant, N);
  assign addr_byte = ADDR_BASE + grant_idx;
  assign accept    = tx_valid && tx_ready;

  rr_arbiter #(.N(N)) u_arb (
    .req (have_msg_bus),
    .ptr (arb_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Length follows the arbiter winner; data follows the latched grant.
  always_comb begin
    sel_len  = 8'h00;
    sel_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (arb_idx == 8'(i))   sel_len  = len_bus[i*8 +: 8];
      if (grant_idx == 8'(i)) sel_data = slave_data_bus[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      rdreq_bus  <= '0;
      busy       <= 1'b0;
      grant_idx  <= 8'h00;
      gnt_q      <= '0;
      last_grant <= 8'(N - 1);
      len_q      <= 8'h00;
      cnt        <= 8'h00;
      chk        <= 8'h00;
    end else begin
      rdreq_bus <= '0;
      if (accept) tx_valid <= 1'b0;

      // state names the byte held in tx_data; a new byte loads only once tx_valid is low
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            gnt_q     <= arb_gnt;
            len_q     <= sel_len;
            cnt       <= sel_len;
            chk       <= 8'h00;
            tx_data   <= SOF;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_SOF;
          end
        end

        ST_SOF: begin
          if (accept) state <= ST_ADDR;
        end

        ST_ADDR: begin
          if (!tx_valid) begin
            tx_data  <= addr_byte;
            chk      <= chk ^ addr_byte;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (!tx_valid) begin
            tx_data  <= len_q;
            chk      <= chk ^ len_q;
            tx_valid <= 1'b1;
            // an empty message still needs one pop to drain the slave's have_msg
            if (cnt == 8'h00) rdreq_bus <= gnt_q;
          end else if (tx_ready) begin
            state <= (cnt == 8'h00) ? ST_CHK : ST_DATA;
          end
        end

        ST_DATA: begin
          if (!tx_valid) begin
            tx_data   <= sel_data;
            chk       <= chk ^ sel_data;
            cnt       <= cnt - 8'd1;
            tx_valid  <= 1'b1;
            rdreq_bus <= gnt_q;
          end else if (tx_ready) begin
            state <= (cnt == 8'h00) ? ST_CHK : ST_DATA;
          end
        end

        ST_CHK: begin
          if (!tx_valid) begin
            tx_data  <= chk;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            last_grant <= grant_idx;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
